// File: rtl/btn_dir_queue.sv
`default_nettype none
// ============================================================================
// Module   : btn_dir_queue
// Brief    : Synchronizes and debounces four touch buttons, turns each press
//            into a 2-bit direction code, queues codes in a small FIFO and
//            releases at most one code per video frame.
// Revision : 1.0 - initial release
// ============================================================================
module btn_dir_queue #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw_i,
  input  logic       frame_tick_i,
  input  logic       ovf_clr_i,
  output logic [1:0] dir_code_o,
  output logic       dir_strobe_o,
  output logic [2:0] fifo_count_o,
  output logic       overflow_o,
  output logic [3:0] btn_level_o
);

  localparam int         C_PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [2:0] C_DEPTH   = 3'(FIFO_DEPTH);
  localparam logic [19:0] C_CNT_MAX = 20'(DEBOUNCE_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Input synchronizer
  // --------------------------------------------------------------------------
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;

  // Two-flop synchronizer per button bit, nothing between the stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce: one counter per button; the stable level only flips after the
  // synchronized input has disagreed with it for DEBOUNCE_CYCLES cycles.
  // --------------------------------------------------------------------------
  logic [3:0] stable_w;

  for (genvar gi = 0; gi < 4; gi++) begin : g_deb
    logic [19:0] cnt_q;
    logic [19:0] cnt_d;
    logic        stable_q;
    logic        stable_d;

    // Count consecutive disagreement; toggle and restart at the terminal count.
    always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync2_q[gi] != stable_q) begin
        if (cnt_q == C_CNT_MAX) begin
          stable_d = ~stable_q;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
    end

    // Debounce state register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end

    assign stable_w[gi] = stable_q;
  end

  // --------------------------------------------------------------------------
  // Press detection and priority encoding
  // --------------------------------------------------------------------------
  logic [3:0] stable_prev_q;
  logic [3:0] press_ev;
  logic       ev_any;
  logic       ev_multi;
  logic [1:0] ev_code;

  // Previous-cycle copy of the stable levels for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_prev_q <= '0;
    end else begin
      stable_prev_q <= stable_w;
    end
  end

  assign press_ev = stable_w & ~stable_prev_q;
  assign ev_any   = |press_ev;
  // More than one bit set: clearing the lowest set bit leaves something.
  assign ev_multi = |(press_ev & (press_ev - 4'd1));

  // Lowest-index press wins; the others are discarded.
  always_comb begin
    ev_code = 2'd0;
    if (press_ev[0]) begin
      ev_code = 2'd0;
    end else if (press_ev[1]) begin
      ev_code = 2'd1;
    end else if (press_ev[2]) begin
      ev_code = 2'd2;
    end else if (press_ev[3]) begin
      ev_code = 2'd3;
    end
  end

  // --------------------------------------------------------------------------
  // Direction FIFO
  // --------------------------------------------------------------------------
  logic [1:0]         mem_q [FIFO_DEPTH];
  logic [C_PTR_W-1:0] wr_ptr_q;
  logic [C_PTR_W-1:0] rd_ptr_q;
  logic [2:0]         count_q;
  logic [2:0]         count_d;
  logic               pop;
  logic               push;
  logic               drop;

  // A pop frees a slot in the same cycle, so a full queue still accepts a
  // push when a tick arrives; an empty queue never forwards a same-cycle push.
  assign pop  = frame_tick_i && (count_q != 3'd0);
  assign push = ev_any && ((count_q != C_DEPTH) || pop);
  assign drop = ev_any && !push;

  // Occupancy next-state.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointers and occupancy; pointers wrap naturally at the depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Storage array; cleared on reset so stale codes can never surface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= ev_code;
    end
  end

  // --------------------------------------------------------------------------
  // Output stage
  // --------------------------------------------------------------------------
  logic [1:0] dir_code_q;
  logic       dir_strobe_q;
  logic       overflow_q;
  logic       overflow_d;

  // Sticky overflow: any lost press sets it, and setting beats clearing.
  always_comb begin
    overflow_d = overflow_q;
    if (ovf_clr_i) begin
      overflow_d = 1'b0;
    end
    if (drop || ev_multi) begin
      overflow_d = 1'b1;
    end
  end

  // Applied direction, update strobe and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_code_q   <= 2'd0;
      dir_strobe_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      if (pop) begin
        dir_code_q <= mem_q[rd_ptr_q];
      end
      dir_strobe_q <= pop;
      overflow_q   <= overflow_d;
    end
  end

  assign dir_code_o   = dir_code_q;
  assign dir_strobe_o = dir_strobe_q;
  assign fifo_count_o = count_q;
  assign overflow_o   = overflow_q;
  assign btn_level_o  = stable_w;

endmodule
`default_nettype wire

// File: doc/btn_dir_queue.md
# btn_dir_queue

Button-to-direction command stage that sits directly upstream of `vga_game` and replaces its raw `direction(touch_btn)` feed. It synchronizes and debounces the four touch buttons and turns each press into a 2-bit direction code. Codes are queued in a 4-entry FIFO and released at most one per video frame, so the game logic sees exactly one clean, frame-aligned direction update per press.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive cycles an input must differ from its stable level before the stable level flips (10 ms at 50 MHz); legal range 2..2^20.
- `FIFO_DEPTH`, default 4: queue depth; fixed power of two, 4.
- `clk`  in  1  pixel/system clock (`clk_50M` at top).
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  4  raw `touch_btn`, asynchronous, 1 = pressed; bit i maps to code i (0 up, 1 down, 2 left, 3 right).
- `frame_tick`  in  1  one-cycle pulse per frame (start of vertical blank), synchronous to `clk`.
- `ovf_clr`  in  1  synchronous clear of `overflow`.
- `dir_code`  out  2  currently applied direction, held between updates.
- `dir_strobe`  out  1  one-cycle pulse: `dir_code` just changed from a FIFO pop.
- `fifo_count`  out  3  entries queued, 0..4.
- `overflow`  out  1  sticky: a press was dropped (FIFO full or lost to priority).
- `btn_level`  out  4  debounced button levels.

## Operation
- Sync: per bit, two flops; no logic between them.
- Debounce, per bit: counter `cnt` (20 bits) and `stable`. If sync output == `stable`, `cnt` <= 0. Otherwise `cnt` increments, and when `cnt` == `DEBOUNCE_CYCLES-1`, `stable` toggles and `cnt` <= 0. `btn_level` = `stable`.
- Press event: bit i rose (`stable[i]` = 1, previous-cycle copy = 0). Releases generate nothing.
- Priority: several events in one cycle → lowest index enqueued; others discarded and `overflow` set.
- FIFO: 4 entries × 2 bits, 2-bit read/write pointers wrapping 3→0, 3-bit count.
  - Push when an event is present and (count < 4 or a pop occurs this cycle).
  - Push while count == 4 with no pop → dropped, `overflow` set.
- Pop when `frame_tick` = 1 and count > 0. `dir_code` <= head entry and `dir_strobe` <= 1. No pop when empty: `dir_code` holds, no strobe. There is no bypass; a push and a tick in the same cycle while empty does not pop.
- Simultaneous push and pop: both occur, count unchanged.
- `overflow`: set by any drop, cleared by `ovf_clr`; set wins if both happen in the same cycle.

## Timing
- Reset (`rst_n` low, asynchronous): all sync flops, `stable`, `cnt`, pointers and count <= 0; `dir_code` = 0, `dir_strobe` = 0, `fifo_count` = 0, `overflow` = 0, `btn_level` = 0. Any queued entries and any partial debounce are discarded. Release is synchronous to `clk` (the top-level reset synchronizer drives `rst_n`).
- Latency, raw edge first sampled at clock edge k:
  - Sync output changes at k+1.
  - `stable` flips at k+1+`DEBOUNCE_CYCLES`.
  - Entry is written and `fifo_count` increments at the next edge, k+2+`DEBOUNCE_CYCLES`.
- Pop: `frame_tick` sampled high at edge T → `dir_code` new value, `dir_strobe` = 1 and `fifo_count` decremented, all visible after T. `dir_strobe` is low after T+1.
- Glitch rejection: a raw pulse shorter than `DEBOUNCE_CYCLES` cycles (after sync) never changes `stable`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- Reset/idle: assert `rst_n`=0 mid-queue with count 3 → all outputs 0 immediately (asynchronous); after release, ticks produce no strobe.
- Single press: `btn_raw`=4'b0100 held 10 cycles, `frame_tick` later → `fifo_count` reaches 1 exactly 6 edges after the raw change. The tick gives `dir_code`=2, `dir_strobe` high one cycle, count returns to 0.
- Glitch: `btn_raw[1]` high for 3 cycles → `btn_level` stays 0, count stays 0.
- Order/full/overflow: press 0, 3, 1, 2, 3 (fully released between presses) with no ticks → count 4, `overflow`=1. Four ticks yield codes 0, 3, 1, 2; a fifth tick gives no strobe. `ovf_clr` → `overflow`=0.
- Simultaneous: buttons 1 and 2 rise in the same cycle → only code 1 queued, `overflow`=1. With count 4, a press event and a tick in the same cycle → pop of the head, push accepted, count stays 4, `overflow` stays 0.
- Empty bypass: with count 0, a press event and a tick in the same cycle → no strobe and count becomes 1; the next tick pops it.
